// File: rtl/scr1_dmi_hs_pkg.sv
// Shared types and DTMCS field positions for the DMI handshake block.
package scr1_dmi_hs_pkg;

  typedef enum logic [1:0] {
    DMI_OP_NOP   = 2'b00,
    DMI_OP_READ  = 2'b01,
    DMI_OP_WRITE = 2'b10,
    DMI_OP_RSVD  = 2'b11
  } type_scr1_dmi_op_e;

  typedef enum logic [1:0] {
    DMI_STAT_OK   = 2'b00,
    DMI_STAT_FAIL = 2'b10,
    DMI_STAT_BUSY = 2'b11
  } type_scr1_dmi_stat_e;

  typedef enum logic {
    DMI_FSM_IDLE = 1'b0,
    DMI_FSM_REQ  = 1'b1
  } type_scr1_dmi_fsm_e;

  localparam int DTMCS_W         = 32;
  localparam int DTMCS_HARDRESET = 17;
  localparam int DTMCS_DMIRESET  = 16;
  localparam int DTMCS_IDLE_LO   = 12;
  localparam int DTMCS_STAT_LO   = 10;
  localparam int DTMCS_ABITS_LO  = 4;

endpackage

// File: rtl/scr1_dmi_tap_dr.sv
// TAP data register: capture/shift with a per-chain active width.
module scr1_dmi_tap_dr #(
  parameter int MAX_W = 41,
  parameter int W0    = 32,
  parameter int W1    = 41
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture,
  input  logic             shift,
  input  logic             tdi,
  input  logic             wsel,
  input  logic [MAX_W-1:0] cap_data,
  output logic [MAX_W-1:0] dr,
  output logic             tdo
);

  logic [MAX_W:0]   dr_ext;
  logic [MAX_W-1:0] shift_val;
  int               w;

  assign dr_ext = {1'b0, dr};
  assign w      = wsel ? W1 : W0;
  assign tdo    = dr[0];

  // TDI lands at the MSB of the active width; bits above it stay zero
  always_comb begin
    shift_val = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i == w - 1)
        shift_val[i] = tdi;
      else if (i < w - 1)
        shift_val[i] = dr_ext[i+1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dr <= '0;
    else if (capture)
      dr <= cap_data;
    else if (shift)
      dr <= shift_val;
  end

endmodule

// File: rtl/scr1_dmi_hs.sv
// DMI between synchronised TAP and DM with stallable req/resp handshake.
// Optional DM response timeout: SCR1_DMI_RESP_TIMEOUT_EN.
module scr1_dmi_hs
  import scr1_dmi_hs_pkg::*;
#(
  parameter int ADDR_WIDTH     = 7,
  parameter int DATA_WIDTH     = 32,
  parameter int CH_ID_WIDTH    = 2,
  parameter int DTMCS_CH_ID    = 1,
  parameter int DMI_CH_ID      = 2,
  parameter int IDLE_HINT      = 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tapcsync2dmi_ch_sel_i,
  input  logic [CH_ID_WIDTH-1:0] tapcsync2dmi_ch_id_i,
  input  logic                   tapcsync2dmi_ch_capture_i,
  input  logic                   tapcsync2dmi_ch_shift_i,
  input  logic                   tapcsync2dmi_ch_update_i,
  input  logic                   tapcsync2dmi_ch_tdi_i,
  output logic                   dmi2tapcsync_ch_tdo_o,
  input  logic                   dm2dmi_resp_i,
  input  logic [DATA_WIDTH-1:0]  dm2dmi_rdata_i,
  output logic                   dmi2dm_req_o,
  output logic                   dmi2dm_wr_o,
  output logic [ADDR_WIDTH-1:0]  dmi2dm_addr_o,
  output logic [DATA_WIDTH-1:0]  dmi2dm_wdata_o
);

  localparam int DMI_W = ADDR_WIDTH + DATA_WIDTH + 2;
  localparam int DR_W  = (DMI_W > DTMCS_W) ? DMI_W : DTMCS_W;

  type_scr1_dmi_fsm_e     fsm;
  logic [1:0]             sticky;
  logic [DATA_WIDTH-1:0]  rdata_ff;
  logic [DR_W-1:0]        dr;
  logic [DR_W-1:0]        cap_data;
  logic [DTMCS_W-1:0]     dtmcs_cap;
  logic [DMI_W-1:0]       dmi_cap;
  logic [1:0]             op_stat;
  logic [1:0]             dr_op;
  logic                   is_dtmcs;
  logic                   is_dmi;
  logic                   cap_dmi;
  logic                   upd_dmi;
  logic                   upd_dtmcs;
  logic                   hard_rst;
  logic                   resp_ok;

`ifdef SCR1_DMI_RESP_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_cnt;
`endif

  assign is_dtmcs = tapcsync2dmi_ch_sel_i &
    (tapcsync2dmi_ch_id_i == CH_ID_WIDTH'(DTMCS_CH_ID));
  assign is_dmi = tapcsync2dmi_ch_sel_i &
    (tapcsync2dmi_ch_id_i == CH_ID_WIDTH'(DMI_CH_ID));

  assign cap_dmi   = tapcsync2dmi_ch_capture_i & is_dmi;
  assign upd_dmi   = tapcsync2dmi_ch_update_i & is_dmi;
  assign upd_dtmcs = tapcsync2dmi_ch_update_i & is_dtmcs;
  assign hard_rst  = upd_dtmcs & dr[DTMCS_HARDRESET];
  assign resp_ok   = (fsm == DMI_FSM_REQ) & dm2dmi_resp_i & ~hard_rst;
  assign dr_op     = dr[1:0];

  assign op_stat = (fsm != DMI_FSM_IDLE) ? DMI_STAT_BUSY : sticky;

  assign dtmcs_cap = {14'd0, 1'b0, 1'b0, 1'b0, 3'(IDLE_HINT),
                      sticky, 6'(ADDR_WIDTH), 4'd1};
  assign dmi_cap   = {dmi2dm_addr_o, rdata_ff, op_stat};
  assign cap_data  = is_dmi ? DR_W'(dmi_cap) : DR_W'(dtmcs_cap);

  scr1_dmi_tap_dr #(
    .MAX_W (DR_W),
    .W0    (DTMCS_W),
    .W1    (DMI_W)
  ) i_dr (
    .clk      (clk),
    .rst_n    (rst_n),
    .capture  (tapcsync2dmi_ch_capture_i & (is_dtmcs | is_dmi)),
    .shift    (tapcsync2dmi_ch_shift_i & (is_dtmcs | is_dmi)),
    .tdi      (tapcsync2dmi_ch_tdi_i),
    .wsel     (is_dmi),
    .cap_data (cap_data),
    .dr       (dr),
    .tdo      (dmi2tapcsync_ch_tdo_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm            <= DMI_FSM_IDLE;
      sticky         <= DMI_STAT_OK;
      rdata_ff       <= '0;
      dmi2dm_req_o   <= 1'b0;
      dmi2dm_wr_o    <= 1'b0;
      dmi2dm_addr_o  <= '0;
      dmi2dm_wdata_o <= '0;
`ifdef SCR1_DMI_RESP_TIMEOUT_EN
      to_cnt         <= '0;
`endif
    end else begin
      if (cap_dmi && fsm != DMI_FSM_IDLE && sticky == DMI_STAT_OK)
        sticky <= DMI_STAT_BUSY;

      if (upd_dmi && sticky == DMI_STAT_OK) begin
        if (fsm != DMI_FSM_IDLE) begin
          sticky <= DMI_STAT_BUSY;
        end else if (dr_op == DMI_OP_READ || dr_op == DMI_OP_WRITE) begin
          fsm            <= DMI_FSM_REQ;
          dmi2dm_req_o   <= 1'b1;
          dmi2dm_wr_o    <= (dr_op == DMI_OP_WRITE);
          dmi2dm_wdata_o <= dr[DATA_WIDTH+1:2];
          dmi2dm_addr_o  <= dr[DMI_W-1:DATA_WIDTH+2];
`ifdef SCR1_DMI_RESP_TIMEOUT_EN
          to_cnt         <= '0;
`endif
        end
      end

      if (resp_ok) begin
        if (!dmi2dm_wr_o)
          rdata_ff <= dm2dmi_rdata_i;
        fsm          <= DMI_FSM_IDLE;
        dmi2dm_req_o <= 1'b0;
      end
`ifdef SCR1_DMI_RESP_TIMEOUT_EN
      else if (fsm == DMI_FSM_REQ) begin
        if (to_cnt == TO_LAST) begin
          fsm          <= DMI_FSM_IDLE;
          dmi2dm_req_o <= 1'b0;
          if (sticky == DMI_STAT_OK)
            sticky <= DMI_STAT_FAIL;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
`endif

      // hard reset overrides a same-cycle response or timeout
      if (upd_dtmcs) begin
        if (dr[DTMCS_DMIRESET] || dr[DTMCS_HARDRESET])
          sticky <= DMI_STAT_OK;
        if (dr[DTMCS_HARDRESET]) begin
          fsm          <= DMI_FSM_IDLE;
          dmi2dm_req_o <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_scr1_dmi_hs.sv
// Self-checking bench for scr1_dmi_hs (scoreboard of DM requests/captures).
module tb_scr1_dmi_hs;

  localparam int AW    = 7;
  localparam int DW    = 32;
  localparam int DMI_W = AW + DW + 2;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sel = 1'b0;
  logic [1:0]    ch_id = '0;
  logic          capture = 1'b0;
  logic          shift = 1'b0;
  logic          update = 1'b0;
  logic          tdi = 1'b0;
  logic          tdo;
  logic          resp = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic          req;
  logic          wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;

  int passed = 0;
  int total  = 0;

  req_t          req_q[$];
  logic [DW-1:0] rd_q[$];

  always #5 clk = ~clk;

  scr1_dmi_hs #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .CH_ID_WIDTH    (2),
    .DTMCS_CH_ID    (1),
    .DMI_CH_ID      (2),
    .IDLE_HINT      (1),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .tapcsync2dmi_ch_sel_i     (sel),
    .tapcsync2dmi_ch_id_i      (ch_id),
    .tapcsync2dmi_ch_capture_i (capture),
    .tapcsync2dmi_ch_shift_i   (shift),
    .tapcsync2dmi_ch_update_i  (update),
    .tapcsync2dmi_ch_tdi_i     (tdi),
    .dmi2tapcsync_ch_tdo_o     (tdo),
    .dm2dmi_resp_i             (resp),
    .dm2dmi_rdata_i            (rdata),
    .dmi2dm_req_o              (req),
    .dmi2dm_wr_o               (wr),
    .dmi2dm_addr_o             (addr),
    .dmi2dm_wdata_o            (wdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // capture, shift w bits, update; optional DM resp during the update cycle
  task automatic scan(input logic [1:0] id, input int w,
                      input logic [63:0] din, input logic upd_resp,
                      input logic [DW-1:0] upd_rdata,
                      output logic [63:0] dout);
    sel = 1'b1;
    ch_id = id;
    capture = 1'b1;
    tick();
    capture = 1'b0;
    shift = 1'b1;
    dout = '0;
    for (int i = 0; i < w; i++) begin
      dout[i] = tdo;
      tdi = din[i];
      tick();
    end
    shift = 1'b0;
    update = 1'b1;
    resp = upd_resp;
    rdata = upd_rdata;
    tick();
    update = 1'b0;
    resp = 1'b0;
    sel = 1'b0;
  endtask

  task automatic issue(input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic expect_req,
                       output logic [63:0] dout);
    req_t r;
    r.wr = w;
    r.addr = a;
    r.data = w ? d : '0;
    if (expect_req)
      req_q.push_back(r);
    scan(2'd2, DMI_W, {23'd0, a, d, (w ? 2'b10 : 2'b01)}, 1'b0, '0, dout);
  endtask

  task automatic test_reset();
    total += 5;
    if (req !== 1'b0) $display("FAIL reset_req got %b want 0", req); else passed++;
    if (wr !== 1'b0) $display("FAIL reset_wr got %b want 0", wr); else passed++;
    if (addr !== '0) $display("FAIL reset_addr got %h want 0", addr); else passed++;
    if (wdata !== '0) $display("FAIL reset_wdata got %h want 0", wdata); else passed++;
    if (tdo !== 1'b0) $display("FAIL reset_tdo got %b want 0", tdo); else passed++;
  endtask

  task automatic test_dtmcs_capture();
    logic [63:0] d;
    scan(2'd1, 32, '0, 1'b0, '0, d);
    total++;
    if (d[31:0] !== 32'h0000_1071)
      $display("FAIL dtmcs_capture got %h want 00001071", d[31:0]);
    else passed++;
  endtask

  task automatic test_write();
    logic [63:0] d;
    req_t e;
    int hi = 0;
    issue(1'b1, 7'h10, 32'hDEAD_BEEF, 1'b1, d);
    e = req_q.pop_front();
    for (int k = 0; k < 5; k++) begin
      total += 4;
      if (req === 1'b1) hi++;
      if (req !== 1'b1) $display("FAIL wr_req c%0d got %b want 1", k, req); else passed++;
      if (wr !== e.wr) $display("FAIL wr_wr c%0d got %b want %b", k, wr, e.wr); else passed++;
      if (addr !== e.addr) $display("FAIL wr_addr c%0d got %h want %h", k, addr, e.addr); else passed++;
      if (wdata !== e.data) $display("FAIL wr_wdata c%0d got %h want %h", k, wdata, e.data); else passed++;
      if (k == 4) resp = 1'b1;
      tick();
    end
    resp = 1'b0;
    total += 2;
    if (req !== 1'b0) $display("FAIL wr_req_drop got %b want 0", req); else passed++;
    if (hi != 5) $display("FAIL wr_req_cycles got %0d want 5", hi); else passed++;
  endtask

  task automatic test_read();
    logic [63:0] d;
    req_t e;
    logic [DW-1:0] exp_d;
    issue(1'b0, 7'h11, '0, 1'b1, d);
    e = req_q.pop_front();
    total += 3;
    if (req !== 1'b1) $display("FAIL rd_req got %b want 1", req); else passed++;
    if (wr !== e.wr) $display("FAIL rd_wr got %b want %b", wr, e.wr); else passed++;
    if (addr !== e.addr) $display("FAIL rd_addr got %h want %h", addr, e.addr); else passed++;
    tick();
    tick();
    resp = 1'b1;
    rdata = 32'h1234_5678;
    rd_q.push_back(32'h1234_5678);
    tick();
    resp = 1'b0;
    rdata = '0;
    scan(2'd2, DMI_W, '0, 1'b0, '0, d);
    exp_d = rd_q.pop_front();
    total += 3;
    if (d[33:2] !== exp_d) $display("FAIL rd_data got %h want %h", d[33:2], exp_d); else passed++;
    if (d[1:0] !== 2'b00) $display("FAIL rd_op got %b want 00", d[1:0]); else passed++;
    if (d[40:34] !== 7'h11) $display("FAIL rd_lastaddr got %h want 11", d[40:34]); else passed++;
  endtask

  task automatic test_busy_sticky();
    logic [63:0] d;
    req_t e;
    issue(1'b0, 7'h05, '0, 1'b1, d);
    e = req_q.pop_front();
    scan(2'd2, DMI_W, '0, 1'b0, '0, d);
    total += 2;
    if (d[1:0] !== 2'b11) $display("FAIL busy_opstat got %b want 11", d[1:0]); else passed++;
    if (addr !== e.addr) $display("FAIL busy_addr_hold got %h want %h", addr, e.addr); else passed++;
    scan(2'd1, 32, '0, 1'b0, '0, d);
    total += 2;
    if (d[11:10] !== 2'b11) $display("FAIL busy_sticky got %b want 11", d[11:10]); else passed++;
    if (req !== 1'b1) $display("FAIL busy_req_hold got %b want 1", req); else passed++;
    resp = 1'b1;
    rdata = 32'hCAFE_F00D;
    tick();
    resp = 1'b0;
    rdata = '0;
    issue(1'b1, 7'h07, 32'h0000_00AA, 1'b0, d);
    total++;
    if (req !== 1'b0) $display("FAIL sticky_ignore got req %b want 0", req); else passed++;
    tick();
    total++;
    if (req !== 1'b0) $display("FAIL sticky_ignore2 got req %b want 0", req); else passed++;
    scan(2'd1, 32, 64'h1_0000, 1'b0, '0, d);
    issue(1'b1, 7'h09, 32'h0000_0001, 1'b1, d);
    e = req_q.pop_front();
    total += 3;
    if (req !== 1'b1) $display("FAIL dmireset_req got %b want 1", req); else passed++;
    if (addr !== e.addr) $display("FAIL dmireset_addr got %h want %h", addr, e.addr); else passed++;
    if (wdata !== e.data) $display("FAIL dmireset_wdata got %h want %h", wdata, e.data); else passed++;
    resp = 1'b1;
    tick();
    resp = 1'b0;
  endtask

  task automatic test_hardreset_resp();
    logic [63:0] d;
    req_t e;
    issue(1'b0, 7'h22, '0, 1'b1, d);
    e = req_q.pop_front();
    total++;
    if (addr !== e.addr) $display("FAIL hr_addr got %h want %h", addr, e.addr); else passed++;
    scan(2'd1, 32, 64'h2_0000, 1'b1, 32'h5555_5555, d);
    total++;
    if (req !== 1'b0) $display("FAIL hr_req got %b want 0", req); else passed++;
    scan(2'd2, DMI_W, '0, 1'b0, '0, d);
    total += 2;
    if (d[33:2] !== 32'hCAFE_F00D) $display("FAIL hr_rdata got %h want cafef00d", d[33:2]); else passed++;
    if (d[1:0] !== 2'b00) $display("FAIL hr_opstat got %b want 00", d[1:0]); else passed++;
    scan(2'd1, 32, '0, 1'b0, '0, d);
    total++;
    if (d[11:10] !== 2'b00) $display("FAIL hr_sticky got %b want 00", d[11:10]); else passed++;
  endtask

`ifdef SCR1_DMI_RESP_TIMEOUT_EN
  task automatic test_timeout();
    logic [63:0] d;
    req_t e;
    int hi = 0;
    issue(1'b1, 7'h30, 32'h0BAD_F00D, 1'b1, d);
    e = req_q.pop_front();
    for (int k = 0; k < 20; k++) begin
      if (req === 1'b1) hi++;
      tick();
    end
    total += 3;
    if (hi != 8) $display("FAIL to_cycles got %0d want 8", hi); else passed++;
    if (addr !== e.addr) $display("FAIL to_addr got %h want %h", addr, e.addr); else passed++;
    scan(2'd1, 32, 64'h1_0000, 1'b0, '0, d);
    if (d[11:10] !== 2'b10) $display("FAIL to_sticky got %b want 10", d[11:10]); else passed++;
  endtask
`endif

  task automatic test_async_reset();
    logic [63:0] d;
    issue(1'b1, 7'h15, 32'h7777_0001, 1'b1, d);
    void'(req_q.pop_front());
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    total += 5;
    if (req !== 1'b0) $display("FAIL arst_req got %b want 0", req); else passed++;
    if (wr !== 1'b0) $display("FAIL arst_wr got %b want 0", wr); else passed++;
    if (addr !== '0) $display("FAIL arst_addr got %h want 0", addr); else passed++;
    if (wdata !== '0) $display("FAIL arst_wdata got %h want 0", wdata); else passed++;
    if (tdo !== 1'b0) $display("FAIL arst_tdo got %b want 0", tdo); else passed++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_dtmcs_capture();
    test_write();
    test_read();
    test_busy_sticky();
    test_hardreset_resp();
`ifdef SCR1_DMI_RESP_TIMEOUT_EN
    test_timeout();
`endif
    test_async_reset();
    test_dtmcs_capture();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
